// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: bundles the fetch, loader and memory-side signals of the
// instruction-memory arbiter.
//   slave  modport: the arbiter's view (takes requests and memory responses,
//                   drives grants, memory requests, routed responses, err).
//   master modport: the environment's view (requesters plus memory).
interface imem_arbiter_if #(
    parameter int INSTR_MEM_IDX_W = 10,
    parameter int INT_DATA_W      = 32
);
    logic                       f_req_valid;
    logic [INSTR_MEM_IDX_W-1:0] f_req_addr;
    logic                       f_req_ready;
    logic                       f_flush;
    logic                       f_resp_valid;
    logic [INT_DATA_W-1:0]      f_resp_data;
    logic                       l_req_valid;
    logic                       l_req_we;
    logic [INSTR_MEM_IDX_W-1:0] l_req_addr;
    logic [INT_DATA_W-1:0]      l_req_wdata;
    logic                       l_req_ready;
    logic                       l_resp_valid;
    logic [INT_DATA_W-1:0]      l_resp_data;
    logic                       mem_req_valid;
    logic                       mem_req_we;
    logic [INSTR_MEM_IDX_W-1:0] mem_req_addr;
    logic [INT_DATA_W-1:0]      mem_req_wdata;
    logic                       mem_resp_valid;
    logic [INT_DATA_W-1:0]      mem_resp_data;
    logic                       err;

    modport slave (
        input  f_req_valid, f_req_addr, f_flush,
        input  l_req_valid, l_req_we, l_req_addr, l_req_wdata,
        input  mem_resp_valid, mem_resp_data,
        output f_req_ready, f_resp_valid, f_resp_data,
        output l_req_ready, l_resp_valid, l_resp_data,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        output err
    );

    modport master (
        output f_req_valid, f_req_addr, f_flush,
        output l_req_valid, l_req_we, l_req_addr, l_req_wdata,
        output mem_resp_valid, mem_resp_data,
        input  f_req_ready, f_resp_valid, f_resp_data,
        input  l_req_ready, l_resp_valid, l_resp_data,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        input  err
    );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares a single-port fixed-latency instruction memory between
// the fetch stage (read-only) and the loader/debug port (read/write).
// Arbitration is combinational; a tag pipeline of depth MEM_LATENCY remembers
// who owns each in-flight read so the response can be routed back, and fetch
// reads killed by f_flush are dropped on return.
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset
//   bus    - imem_arbiter_if.slave: fetch request/flush/response, loader
//            request/response, memory request/response, sticky err
// Optional feature: define IMEM_ARB_STARVE_GUARD_EN to enable the loader
// starvation counter (forced loader grant after STARVE_LIMIT denied cycles).
module imem_arbiter #(
    parameter int INSTR_MEM_IDX_W = 10,
    parameter int INT_DATA_W      = 32,
    parameter int MEM_LATENCY     = 1,
    parameter int STARVE_LIMIT    = 8
) (
    input logic           clk,
    input logic           rst_n,
    imem_arbiter_if.slave bus
);
    localparam logic OWNER_FETCH  = 1'b0;
    localparam logic OWNER_LOADER = 1'b1;

    typedef struct packed {
        logic valid;
        logic owner;
        logic killed;
    } tag_t;

    tag_t [MEM_LATENCY-1:0] tags_r;
    tag_t [MEM_LATENCY-1:0] tags_next_s;
    tag_t                   exit_s;
    logic                   exit_killed_s;
    logic                   resp_hit_s;
    logic                   f_grant_s;
    logic                   l_grant_s;
    logic                   starve_s;
    logic                   err_r;

`ifdef IMEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;

    // Loader forced to win once it has been denied STARVE_LIMIT cycles in a row.
    always_comb begin
        starve_s = bus.l_req_valid && (cnt_r == CNT_W'(STARVE_LIMIT));
    end

    // Count consecutive denied loader cycles, saturating at the limit.
    always_comb begin
        cnt_next_s = '0;
        if (bus.l_req_valid && !l_grant_s) begin
            if (cnt_r == CNT_W'(STARVE_LIMIT)) begin
                cnt_next_s = cnt_r;
            end else begin
                cnt_next_s = cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_next_s = '0;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_next_s;
        end
    end
`else
    // Strict fetch priority: the loader is never forced in.
    always_comb begin
        starve_s = 1'b0;
    end
`endif

    // Grant selection; all grants are suppressed while reset is held.
    always_comb begin
        f_grant_s = 1'b0;
        l_grant_s = 1'b0;
        if (rst_n) begin
            if (bus.f_req_valid && !bus.f_flush && !starve_s) begin
                f_grant_s = 1'b1;
            end else if (bus.l_req_valid) begin
                l_grant_s = 1'b1;
            end else begin
                f_grant_s = 1'b0;
                l_grant_s = 1'b0;
            end
        end else begin
            f_grant_s = 1'b0;
            l_grant_s = 1'b0;
        end
    end

    // Memory request driven from the winner; address and data zero when idle.
    always_comb begin
        bus.f_req_ready   = f_grant_s;
        bus.l_req_ready   = l_grant_s;
        bus.mem_req_valid = f_grant_s | l_grant_s;
        bus.mem_req_we    = l_grant_s & bus.l_req_we;
        bus.mem_req_addr  = '0;
        bus.mem_req_wdata = '0;
        if (f_grant_s) begin
            bus.mem_req_addr = bus.f_req_addr;
        end else if (l_grant_s) begin
            bus.mem_req_addr  = bus.l_req_addr;
            bus.mem_req_wdata = bus.l_req_wdata;
        end else begin
            bus.mem_req_addr  = '0;
            bus.mem_req_wdata = '0;
        end
    end

    // Response routing against the exiting tag; a flush in the exit cycle
    // still kills a fetch response.
    always_comb begin
        exit_s           = tags_r[MEM_LATENCY-1];
        exit_killed_s    = exit_s.killed | (bus.f_flush & (exit_s.owner == OWNER_FETCH));
        resp_hit_s       = rst_n & bus.mem_resp_valid & exit_s.valid;
        bus.f_resp_valid = resp_hit_s & (exit_s.owner == OWNER_FETCH) & !exit_killed_s;
        bus.l_resp_valid = resp_hit_s & (exit_s.owner == OWNER_LOADER);
        bus.f_resp_data  = bus.f_resp_valid ? bus.mem_resp_data : '0;
        bus.l_resp_data  = bus.l_resp_valid ? bus.mem_resp_data : '0;
        bus.err          = err_r;
    end

    // Next tag pipeline: shift by one, kill fetch entries on flush, and insert
    // a tag for a read grant (writes insert an empty slot).
    always_comb begin
        tags_next_s = '0;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            tags_next_s[i] = tags_r[i-1];
            if (bus.f_flush && tags_r[i-1].valid && (tags_r[i-1].owner == OWNER_FETCH)) begin
                tags_next_s[i].killed = 1'b1;
            end else begin
                tags_next_s[i].killed = tags_r[i-1].killed;
            end
        end
        tags_next_s[0].valid  = f_grant_s | (l_grant_s & !bus.l_req_we);
        tags_next_s[0].owner  = l_grant_s ? OWNER_LOADER : OWNER_FETCH;
        tags_next_s[0].killed = 1'b0;
    end

    // Tag pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tags_r <= '0;
        end else begin
            tags_r <= tags_next_s;
        end
    end

    // Sticky protocol error: response without a read, or a read without response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if ((bus.mem_resp_valid && !exit_s.valid) ||
                     (exit_s.valid && !bus.mem_resp_valid)) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end
endmodule
